wf_neopixel_rx: RTL and testbench

WF_NEOPIXEL_RX -- requirements
Module: WF_neopixel_rx

---
 rtl/wf_neopixel_rx.sv | 167 ++++++++++++++++
 tb/tb_wf_neopixel_rx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wf_neopixel_rx.sv
`timescale 1ns/1ps
`default_nettype none
// wf_neopixel_rx: decodes a neopixel serial stream into 24-bit pixels (bit 0 received first),
// with per-frame pixel counting and one-clock pulses for pixel, frame end and framing errors.
module wf_neopixel_rx #(
  parameter int BIT1_MIN   = 8,
  parameter int HI_MIN     = 2,
  parameter int HI_MAX     = 14,
  parameter int RESET_CLKS = 600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        DIN,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic [7:0]  pixel_index,
  output logic        frame_done,
  output logic [7:0]  pixel_count,
  output logic        rx_error
);

  localparam int              LW         = $clog2(RESET_CLKS + 1);
  localparam logic [3:0]      C_BIT1_MIN = 4'(BIT1_MIN);
  localparam logic [3:0]      C_HI_MIN   = 4'(HI_MIN);
  localparam logic [3:0]      C_HI_MAX   = 4'(HI_MAX);
  localparam logic [LW-1:0]   C_LO_LAST  = LW'(RESET_CLKS - 1);

  typedef enum logic [1:0] {SYNC, ARMED, HIGH, LOW} state_t;

  state_t        state, state_nx;
  logic          sync1, din_s;
  logic [3:0]    hi_cnt, hi_nx;
  logic [LW-1:0] lo_cnt, lo_nx;
  logic [4:0]    bit_cnt, bit_nx;
  logic [7:0]    pix_cnt, pix_nx;
  logic [23:0]   shift_reg, shift_nx;
  logic          pend, pend_nx;
  logic [23:0]   data_nx;
  logic [7:0]    index_nx, count_nx;
  logic          valid_nx, done_nx, err_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= 1'b0;
      din_s       <= 1'b0;
      state       <= SYNC;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= '0;
      pix_cnt     <= '0;
      shift_reg   <= '0;
      pend        <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      rx_error    <= 1'b0;
    end else begin
      sync1       <= DIN;
      din_s       <= sync1;
      state       <= state_nx;
      hi_cnt      <= hi_nx;
      lo_cnt      <= lo_nx;
      bit_cnt     <= bit_nx;
      pix_cnt     <= pix_nx;
      shift_reg   <= shift_nx;
      pend        <= pend_nx;
      pixel_data  <= data_nx;
      pixel_valid <= valid_nx;
      pixel_index <= index_nx;
      frame_done  <= done_nx;
      pixel_count <= count_nx;
      rx_error    <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    hi_nx    = hi_cnt;
    lo_nx    = lo_cnt;
    bit_nx   = bit_cnt;
    pix_nx   = pix_cnt;
    shift_nx = shift_reg;
    pend_nx  = 1'b0;
    data_nx  = pixel_data;
    index_nx = pixel_index;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    count_nx = pixel_count;
    err_nx   = 1'b0;

    // A pixel completed on the previous clock is published one clock after its last bit decision.
    if (pend) begin
      data_nx  = shift_reg;
      index_nx = pix_cnt;
      valid_nx = 1'b1;
      pix_nx   = pix_cnt + 8'd1;
    end

    case (state)
      SYNC: begin
        if (din_s) begin
          lo_nx = '0;
        end else if (lo_cnt == C_LO_LAST) begin
          lo_nx    = '0;
          state_nx = ARMED;
        end else begin
          lo_nx = lo_cnt + 1'b1;
        end
      end
      ARMED: begin
        if (din_s) begin
          state_nx = HIGH;
          hi_nx    = 4'd1;
          bit_nx   = '0;
          pix_nx   = '0;
          shift_nx = '0;
        end
      end
      HIGH: begin
        if (din_s) begin
          // Flag as soon as the pulse would exceed HI_MAX rather than waiting for its end.
          if (hi_cnt >= C_HI_MAX) begin
            err_nx   = 1'b1;
            lo_nx    = '0;
            state_nx = SYNC;
          end else begin
            hi_nx = (hi_cnt == 4'hF) ? hi_cnt : hi_cnt + 4'd1;
          end
        end else if (hi_cnt < C_HI_MIN) begin
          err_nx   = 1'b1;
          lo_nx    = '0;
          state_nx = SYNC;
        end else begin
          shift_nx[bit_cnt] = (hi_cnt >= C_BIT1_MIN);
          lo_nx    = LW'(1);
          state_nx = LOW;
          if (bit_cnt == 5'd23) begin
            bit_nx  = '0;
            pend_nx = 1'b1;
          end else begin
            bit_nx = bit_cnt + 5'd1;
          end
        end
      end
      LOW: begin
        if (din_s) begin
          state_nx = HIGH;
          hi_nx    = 4'd1;
        end else if (lo_cnt == C_LO_LAST) begin
          done_nx  = 1'b1;
          count_nx = pix_cnt;
          err_nx   = (bit_cnt != 5'd0);
          bit_nx   = '0;
          lo_nx    = '0;
          state_nx = ARMED;
        end else begin
          lo_nx = lo_cnt + 1'b1;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wf_neopixel_rx.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for wf_neopixel_rx: pulse-width streams are replayed on DIN and the observed events are
// compared with a pulse-level decoder model.
module tb_wf_neopixel_rx;

  localparam int BIT1_MIN   = 8;
  localparam int HI_MIN     = 2;
  localparam int HI_MAX     = 14;
  localparam int RESET_CLKS = 600;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  pixel_count;
  logic        rx_error;

  always #42 clk = ~clk;

  wf_neopixel_rx #(
    .BIT1_MIN(BIT1_MIN), .HI_MIN(HI_MIN), .HI_MAX(HI_MAX), .RESET_CLKS(RESET_CLKS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .DIN(din),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .pixel_count(pixel_count), .rx_error(rx_error)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int          stim_hi[$];
  int          stim_lo[$];
  int          fall_cyc[$];
  int          rise_cyc[$];
  logic [31:0] exp_pix[$];
  int          exp_done[$];
  int          exp_err;
  logic [31:0] mon_pix[$];
  int          mon_valid_cyc[$];
  int          mon_done[$];
  int          mon_err = 0;
  int          mon_err_cyc[$];
  int          overlap = 0;
  int          hold_viol = 0;
  logic [23:0] last_data = '0;
  logic [7:0]  last_idx = '0;

  always @(negedge clk) begin
    if (!reset_n) begin
      last_data = '0;
      last_idx  = '0;
    end else begin
      if (pixel_valid) begin
        mon_pix.push_back({pixel_index, pixel_data});
        mon_valid_cyc.push_back(cyc);
        last_data = pixel_data;
        last_idx  = pixel_index;
      end else if (pixel_data !== last_data || pixel_index !== last_idx) begin
        hold_viol++;
      end
      if (frame_done) mon_done.push_back(int'(pixel_count));
      if (rx_error) begin
        mon_err++;
        mon_err_cyc.push_back(cyc);
      end
      if (pixel_valid && (frame_done || rx_error)) overlap++;
    end
  end

  initial begin
    #8_000_000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 8ms", $time);
    $fatal(1);
  end

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic hold(logic v, int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_word(logic [23:0] w, int h1, int h0, int l1, int l0);
    for (int i = 0; i < 24; i++) begin
      stim_hi.push_back(w[i] ? h1 : h0);
      stim_lo.push_back(w[i] ? l1 : l0);
    end
  endtask

  task automatic add_rand_bits(int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(1, 0) == 1) stim_hi.push_back(int'($urandom_range(HI_MAX, BIT1_MIN)));
      else                           stim_hi.push_back(int'($urandom_range(BIT1_MIN - 1, HI_MIN)));
      stim_lo.push_back(int'($urandom_range(20, 1)));
    end
  endtask

  task automatic end_frame();
    stim_lo[stim_lo.size() - 1] = RESET_CLKS;
  endtask

  // Pulse-level decoder: each high width is a bit, a glitch or an overlong error; a low of
  // RESET_CLKS or more ends the frame (or re-arms after an error).
  task automatic run_model(bit start_alive);
    bit          alive;
    logic [23:0] word;
    int          nbits, npix;
    alive = start_alive; word = '0; nbits = 0; npix = 0;
    exp_pix.delete(); exp_done.delete(); exp_err = 0;
    for (int i = 0; i < stim_hi.size(); i++) begin
      if (alive) begin
        if (stim_hi[i] < HI_MIN || stim_hi[i] > HI_MAX) begin
          exp_err++;
          alive = 1'b0;
        end else begin
          word[nbits] = (stim_hi[i] >= BIT1_MIN);
          nbits++;
          if (nbits == 24) begin
            exp_pix.push_back({8'(npix % 256), word});
            npix++;
            nbits = 0;
          end
        end
      end
      if (stim_lo[i] >= RESET_CLKS) begin
        if (alive) begin
          exp_done.push_back(npix % 256);
          if (nbits != 0) exp_err++;
        end
        alive = 1'b1; nbits = 0; npix = 0;
      end
    end
  endtask

  task automatic play();
    fall_cyc.delete(); rise_cyc.delete();
    for (int i = 0; i < stim_hi.size(); i++) begin
      rise_cyc.push_back(cyc + 1);
      hold(1'b1, stim_hi[i]);
      fall_cyc.push_back(cyc);
      hold(1'b0, stim_lo[i]);
    end
    hold(1'b0, 8);
  endtask

  task automatic clear_all();
    stim_hi.delete(); stim_lo.delete();
    mon_pix.delete(); mon_valid_cyc.delete(); mon_done.delete(); mon_err_cyc.delete();
    mon_err = 0;
  endtask

  task automatic compare(string tag);
    check({tag, ".npix"}, mon_pix.size(), exp_pix.size());
    for (int k = 0; k < exp_pix.size() && k < mon_pix.size(); k++) begin
      check($sformatf("%s.pix%0d.data", tag, k), {8'h00, mon_pix[k][23:0]}, {8'h00, exp_pix[k][23:0]});
      check($sformatf("%s.pix%0d.index", tag, k), {24'h0, mon_pix[k][31:24]}, {24'h0, exp_pix[k][31:24]});
    end
    check({tag, ".ndone"}, mon_done.size(), exp_done.size());
    for (int k = 0; k < exp_done.size() && k < mon_done.size(); k++)
      check($sformatf("%s.count%0d", tag, k), mon_done[k], exp_done[k]);
    check({tag, ".nerr"}, mon_err, exp_err);
  endtask

  task automatic scenario(string tag, bit start_alive);
    run_model(start_alive);
    play();
    compare(tag);
  endtask

  initial begin
    logic [23:0] words[3];
    int          d;
    words[0] = 24'h0000FF; words[1] = 24'hFF0000; words[2] = 24'h00A5A5;

    repeat (3) @(posedge clk);
    #1;
    check("rst.pixel_data", pixel_data, 0);
    check("rst.pixel_valid", pixel_valid, 0);
    check("rst.pixel_index", pixel_index, 0);
    check("rst.frame_done", frame_done, 0);
    check("rst.pixel_count", pixel_count, 0);
    check("rst.rx_error", rx_error, 0);
    reset_n = 1'b1;
    hold(1'b0, RESET_CLKS);

    clear_all();
    add_word(24'h555555, 10, 5, 5, 10);
    end_frame();
    scenario("basic", 1'b1);
    check("basic.const_data", mon_pix.size() > 0 ? {8'h00, mon_pix[0][23:0]} : 32'hFFFF_FFFF, 32'h0055_5555);
    d = mon_valid_cyc.size() > 0 ? mon_valid_cyc[0] - fall_cyc[23] : -1;
    check("basic.latency", d, 4);

    clear_all();
    for (int k = 0; k < 3; k++) add_word(words[k], 10, 5, 5, 10);
    end_frame();
    scenario("three", 1'b1);
    for (int k = 0; k < 3; k++)
      check($sformatf("three.const%0d", k), mon_pix.size() > k ? {8'h00, mon_pix[k][23:0]} : 32'hFFFF_FFFF,
            {8'h00, words[k]});

    clear_all();
    add_rand_bits(24);
    stim_hi[0] = BIT1_MIN - 1;
    stim_hi[1] = BIT1_MIN;
    end_frame();
    scenario("thresh", 1'b1);
    check("thresh.bits10", mon_pix.size() > 0 ? {30'h0, mon_pix[0][1:0]} : 32'hFFFF_FFFF, 32'h2);

    clear_all();
    add_rand_bits(5);
    stim_hi.push_back(1); stim_lo.push_back(5);
    add_rand_bits(5);
    end_frame();
    scenario("glitch", 1'b1);

    clear_all();
    add_rand_bits(24);
    end_frame();
    scenario("rearm", 1'b1);

    clear_all();
    add_rand_bits(10);
    stim_hi.push_back(20); stim_lo.push_back(5);
    add_rand_bits(4);
    end_frame();
    scenario("overlong", 1'b1);
    d = mon_err_cyc.size() > 0 ? mon_err_cyc[0] - rise_cyc[10] : 99;
    check("overlong.latency_ok", (d >= 0 && d <= 16), 1);

    clear_all();
    add_rand_bits(48);
    end_frame();
    scenario("after_overlong", 1'b1);

    clear_all();
    add_rand_bits(12);
    end_frame();
    scenario("partial", 1'b1);

    clear_all();
    add_rand_bits(96);
    end_frame();
    scenario("random", 1'b1);

    clear_all();
    add_rand_bits(10);
    scenario("pre_reset", 1'b1);
    reset_n = 1'b0;
    hold(1'b0, 3);
    check("midrst.pixel_data", pixel_data, 0);
    check("midrst.pixel_index", pixel_index, 0);
    check("midrst.pixel_count", pixel_count, 0);
    reset_n = 1'b1;
    clear_all();
    add_rand_bits(38);
    end_frame();
    add_rand_bits(48);
    end_frame();
    scenario("post_reset", 1'b0);

    clear_all();
    for (int k = 0; k < 257; k++) add_word(24'($urandom), BIT1_MIN, HI_MIN, 1, 1);
    end_frame();
    scenario("wrap", 1'b1);
    check("wrap.count_const", mon_done.size() > 0 ? mon_done[0] : -1, 1);

    check("exclusive_pulses", overlap, 0);
    check("hold_between_valid", hold_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
